// File: rtl/multi_arbiter.sv
// Round-robin front end for one shared multi-cycle compute unit: accepts a single
// request, starts the unit, waits for done (with timeout) and returns the result.
module multi_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]       resp_data,
   output logic                   resp_error,
   output logic                   unit_start,
   output logic [WIDTH-1:0]       unit_inp,
   output logic                   unit_reset,
   input  logic                   unit_done,
   input  logic [WIDTH-1:0]       unit_out,
   output logic                   busy,
   output logic [1:0]             o_dbg_state
);

   // Handshake: a request transfers in the IDLE cycle where req_valid[g] and
   // req_ready[g] are both high; req_ready is combinational and at most one-hot.
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] C_LAST_WAIT = CW'(TIMEOUT - 1);
   localparam logic [GW-1:0] C_LAST_REQ  = GW'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [GW-1:0]     r_last;
   logic [GW-1:0]     r_grant;
   logic [CW-1:0]     r_wait_cnt;
   logic              r_unit_start;
   logic [WIDTH-1:0]  r_unit_inp;
   logic [N_REQ-1:0]  r_resp_valid;
   logic [WIDTH-1:0]  r_resp_data;
   logic              r_resp_error;

   logic [GW-1:0]     w_winner;
   logic              w_any;
   logic [GW:0]       w_sum;
   logic [N_REQ-1:0]  w_win_onehot;
   logic [N_REQ-1:0]  w_grant_onehot;
   logic [WIDTH-1:0]  w_sel;

   // Scan downward so the candidate closest after r_last is the one that sticks.
   always_comb begin
      w_winner = r_last;
      w_any    = 1'b0;
      w_sum    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_sum = {1'b0, r_last} + (GW+1)'(k);
         if (w_sum >= (GW+1)'(N_REQ)) w_sum = w_sum - (GW+1)'(N_REQ);
         if (req_valid[w_sum[GW-1:0]]) begin
            w_any    = 1'b1;
            w_winner = w_sum[GW-1:0];
         end
      end
   end

   always_comb begin
      w_sel          = '0;
      w_win_onehot   = '0;
      w_grant_onehot = '0;
      w_win_onehot[w_winner]  = 1'b1;
      w_grant_onehot[r_grant] = 1'b1;
      for (int i = 0; i < N_REQ; i++)
         if (w_winner == GW'(i)) w_sel = req_data[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last       <= C_LAST_REQ;
         r_grant      <= '0;
         r_wait_cnt   <= '0;
         r_unit_start <= 1'b0;
         r_unit_inp   <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         r_resp_error <= 1'b0;
      end else begin
         r_unit_start <= 1'b0;
         r_unit_inp   <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         r_resp_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant      <= w_winner;
                  r_last       <= w_winner;
                  r_unit_start <= 1'b1;
                  r_unit_inp   <= w_sel;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // done takes precedence over a timeout landing in the same cycle
               if (unit_done) begin
                  r_resp_valid <= w_grant_onehot;
                  r_resp_data  <= unit_out;
                  r_state      <= S_RESP;
               end else if (r_wait_cnt == C_LAST_WAIT) begin
                  r_resp_valid <= w_grant_onehot;
                  r_resp_error <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_RESP: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (r_state == S_IDLE && w_any && !reset) ? w_win_onehot : '0;
   assign resp_valid  = r_resp_valid;
   assign resp_data   = r_resp_data;
   assign resp_error  = r_resp_error;
   assign unit_start  = r_unit_start;
   assign unit_inp    = r_unit_inp;
   assign unit_reset  = reset | (r_state == S_RESP && r_resp_error);
   assign busy        = (r_state != S_IDLE);
   assign o_dbg_state = r_state;

endmodule
